opcode_issuer: RTL

OPCODE_ISSUER -- requirements
Module: opcode_issuer

---
 rtl/opcode_issuer_pkg.sv | 17 +
 rtl/opcode_issuer_if.sv | 11 +
 rtl/opcode_issuer_gravity_timer.sv | 61 ++++++
 rtl/opcode_issuer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/opcode_issuer_pkg.sv
// Shared Tetris command types used by the opcode issuer and its FIFO.
// Optional feature macro: OPCODE_ISSUER_SPEEDUP_EN (see opcode_issuer.sv).
package tetris;

    localparam int OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        eNew       = 3'd0,
        eMoveLeft  = 3'd1,
        eMoveRight = 3'd2,
        eMoveDown  = 3'd3,
        eRotate    = 3'd4,
        eCommit    = 3'd5,
        eCheck     = 3'd6
    } opcode_e;

endpackage

// File: rtl/opcode_issuer_if.sv
// Command-FIFO write port: the issuer drives opcode/strobe, the FIFO answers full.
interface opcode_issuer_if;
    import tetris::*;

    opcode_e opcode_o;
    logic    opcode_write_o;
    logic    opcode_full_i;

    modport master (output opcode_o, output opcode_write_o, input opcode_full_i);
    modport slave  (input opcode_o, input opcode_write_o, output opcode_full_i);
endinterface

// File: rtl/opcode_issuer_gravity_timer.sv
// Gravity timer: counts play cycles and requests an automatic move-down.
// With OPCODE_ISSUER_SPEEDUP_EN the period shrinks per cleared line.
module gravity_timer #(
    parameter int gravity_period_p = 25000000,
    parameter int min_period_p     = 2500000,
    parameter int speedup_step_p   = 1000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    input  logic reload_i,
`ifdef OPCODE_ISSUER_SPEEDUP_EN
    input  logic line_i,
    input  logic restart_i,
`endif
    output logic tick_o
);
    localparam logic [31:0] GRAV_LP = 32'(gravity_period_p);

    logic [31:0] r_count;
    logic [31:0] w_period;

`ifdef OPCODE_ISSUER_SPEEDUP_EN
    localparam logic [31:0] MIN_LP  = 32'(min_period_p);
    localparam logic [31:0] STEP_LP = 32'(speedup_step_p);

    logic [31:0] r_period;

    function automatic logic [31:0] shrink_period(input logic [31:0] period);
        logic [31:0] result;
        if (period >= MIN_LP + STEP_LP) result = period - STEP_LP;
        else                            result = MIN_LP;
        return result;
    endfunction

    // Period register: shortened per cleared line, restored when a game starts.
    always_ff @(posedge clk_i) begin
        if (reset_i)        r_period <= GRAV_LP;
        else if (restart_i) r_period <= GRAV_LP;
        else if (line_i)    r_period <= shrink_period(r_period);
    end

    assign w_period = r_period;
`else
    localparam int unused_cfg_lp = min_period_p + speedup_step_p;

    assign w_period = GRAV_LP;
`endif

    // The counter saturates at period-1 so a blocked tick stays asserted until
    // the move-down is finally written and reloads it.
    assign tick_o = enable_i && (r_count >= w_period - 32'd1);

    // Gravity counter: runs only while enabled, restarts on each move-down write.
    always_ff @(posedge clk_i) begin
        if (reset_i)                    r_count <= '0;
        else if (reload_i)              r_count <= '0;
        else if (enable_i && !tick_o)   r_count <= r_count + 32'd1;
    end

endmodule

// File: rtl/opcode_issuer.sv
// Opcode issuer: turns button pulses, gravity ticks and plate events into
// a stream of opcodes for the command FIFO.
// Optional feature macro: OPCODE_ISSUER_SPEEDUP_EN (line clears speed up gravity).
module opcode_issuer
    import tetris::*;
#(
    parameter int gravity_period_p = 25000000,
    parameter int min_period_p     = 2500000,
    parameter int speedup_step_p   = 1000000
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            left_i,
    input  logic            right_i,
    input  logic            down_i,
    input  logic            rotate_i,
    input  logic            landed_i,
    input  logic            line_elimination_i,
    input  logic            lose_i,
    opcode_issuer_if.master fifo_if,
    output logic            playing_o
);
    typedef enum logic [2:0] {
        eIdle, eSpawn, ePlay, eCommitIss, eCheckIss, eLostWait
    } state_e;

    state_e  r_state, w_state_next;
    logic    r_pend_left, r_pend_right, r_pend_down, r_pend_rot, r_pend_landed;
    logic    r_lock;
    opcode_e r_lock_op;
    opcode_e w_opcode;
    logic    w_write, w_accept, w_in_play, w_tick, w_clear_moves, w_drop_all;

    function automatic logic next_flag(input logic pend, input logic set,
                                       input logic written, input logic drop);
        return (written || drop) ? 1'b0 : (pend || set);
    endfunction

    assign w_in_play     = (r_state == ePlay);
    assign w_accept      = w_write && !fifo_if.opcode_full_i;
    assign w_drop_all    = (w_state_next == eLostWait);
    assign w_clear_moves = (w_state_next == eCommitIss) || w_drop_all;

    // Next state and write request; a held opcode keeps priority until written.
    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_opcode     = eNew;
        case (r_state)
            eIdle:      if (start_i) w_state_next = eSpawn;
            eSpawn: begin
                w_write  = 1'b1;
                w_opcode = eNew;
                if (!fifo_if.opcode_full_i) w_state_next = ePlay;
            end
            ePlay: begin
                if (r_lock) begin
                    w_write  = 1'b1;
                    w_opcode = r_lock_op;
                end else if (landed_i || r_pend_landed) begin
                    w_state_next = eCommitIss;
                end else if (r_pend_rot) begin
                    w_write  = 1'b1;
                    w_opcode = eRotate;
                end else if (r_pend_left) begin
                    w_write  = 1'b1;
                    w_opcode = eMoveLeft;
                end else if (r_pend_right) begin
                    w_write  = 1'b1;
                    w_opcode = eMoveRight;
                end else if (r_pend_down || w_tick) begin
                    w_write  = 1'b1;
                    w_opcode = eMoveDown;
                end
            end
            eCommitIss: begin
                w_write  = 1'b1;
                w_opcode = eCommit;
                if (!fifo_if.opcode_full_i) w_state_next = eCheckIss;
            end
            eCheckIss: begin
                w_write  = 1'b1;
                w_opcode = eCheck;
                if (!fifo_if.opcode_full_i) w_state_next = eSpawn;
            end
            eLostWait:  if (start_i && !lose_i) w_state_next = eSpawn;
            default:    w_state_next = eIdle;
        endcase
        if (lose_i) begin
            w_state_next = eLostWait;
            w_write      = 1'b0;
            w_opcode     = eNew;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= eIdle;
        else         r_state <= w_state_next;
    end

    // Pending request flags: set by pulses in play, cleared when written or dropped.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pend_left   <= 1'b0;
            r_pend_right  <= 1'b0;
            r_pend_down   <= 1'b0;
            r_pend_rot    <= 1'b0;
            r_pend_landed <= 1'b0;
        end else begin
            r_pend_left   <= next_flag(r_pend_left, w_in_play && left_i,
                                       w_accept && (w_opcode == eMoveLeft), w_clear_moves);
            r_pend_right  <= next_flag(r_pend_right, w_in_play && right_i,
                                       w_accept && (w_opcode == eMoveRight), w_clear_moves);
            r_pend_down   <= next_flag(r_pend_down, w_in_play && (down_i || w_tick),
                                       w_accept && (w_opcode == eMoveDown), w_clear_moves);
            r_pend_rot    <= next_flag(r_pend_rot, w_in_play && rotate_i,
                                       w_accept && (w_opcode == eRotate), w_clear_moves);
            r_pend_landed <= next_flag(r_pend_landed, w_in_play && landed_i,
                                       w_accept && (w_opcode == eCommit), w_drop_all);
        end
    end

    // Hold flag: a play-state write stalled on full freezes its opcode.
    always_ff @(posedge clk_i) begin
        if (reset_i) r_lock <= 1'b0;
        else         r_lock <= w_in_play && w_write && fifo_if.opcode_full_i;
    end

    // Opcode captured every cycle; only consulted while the hold flag is set.
    always_ff @(posedge clk_i) begin
        r_lock_op <= w_opcode;
    end

    gravity_timer #(
        .gravity_period_p (gravity_period_p),
        .min_period_p     (min_period_p),
        .speedup_step_p   (speedup_step_p)
    ) u_gravity (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .enable_i  (w_in_play),
        .reload_i  (w_accept && (w_opcode == eMoveDown)),
`ifdef OPCODE_ISSUER_SPEEDUP_EN
        .line_i    (line_elimination_i),
        .restart_i (start_i),
`endif
        .tick_o    (w_tick)
    );

`ifndef OPCODE_ISSUER_SPEEDUP_EN
    logic w_unused_line;
    assign w_unused_line = line_elimination_i;
`endif

    assign fifo_if.opcode_o       = w_opcode;
    assign fifo_if.opcode_write_o = w_write;
    assign playing_o              = w_in_play;

endmodule
